seq_divider: RTL and testbench

- Iterative 32-bit restoring divider for the M-extension DIV/DIVU/REM/REMU path of the sail-core ALU.
- Sits directly upstream and downstream of the DSP subtractor instance:
  - drives the subtractor's minuend and subtrahend each cycle;
  - consumes its difference and carry to decide each quotient bit.
- Produces one quotient bit per cycle, with a single-cycle handshake to the ALU.

---
 rtl/seq_divider_if.sv | 27 ++
 rtl/seq_divider.sv | 154 +++++++++++++++
 tb/tb_seq_divider.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// seq_divider_if: request/result bundle between the ALU and the iterative divider.
//   start/flush/op_signed/dividend/divisor : ALU -> divider request side
//   busy/result_valid/quotient/remainder   : divider -> ALU result side
// master modport is the ALU view, slave modport is the divider view.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             flush;
  logic             op_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             result_valid;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, flush, op_signed, dividend, divisor,
    input  busy, result_valid, quotient, remainder
  );

  modport slave (
    input  start, flush, op_signed, dividend, divisor,
    output busy, result_valid, quotient, remainder
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// The subtraction itself lives in an external subtractor: this block drives sub_a/sub_b and
// consumes sub_diff/sub_no_borrow combinationally in the same cycle.
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : start/flush/op_signed/dividend/divisor in,
//                       busy/result_valid/quotient/remainder out
//   sub_a, sub_b      : minuend/subtrahend to the subtractor (0 outside ITER)
//   sub_diff          : sub_a - sub_b mod 2^WIDTH
//   sub_no_borrow     : 1 when sub_a >= sub_b (unsigned)
// Optional feature macro SEQ_DIV_SIGNED_EN: when defined, op_signed selects signed division
// and a FIX state restores result signs (latency 34); otherwise all operations are unsigned
// (latency 33).
module seq_divider #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned COUNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  seq_divider_if.slave     bus,
  output logic [WIDTH-1:0] sub_a,
  output logic [WIDTH-1:0] sub_b,
  input  logic [WIDTH-1:0] sub_diff,
  input  logic             sub_no_borrow
);

  typedef enum logic [1:0] {StIdle, StIter, StFix, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   quo_q, quo_d;        // working quotient, shifts in from the right
  logic [WIDTH-1:0]   rem_q, rem_d;        // partial remainder
  logic [WIDTH-1:0]   dvs_q, dvs_d;        // divisor magnitude
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;

  logic               signed_op;
  logic [WIDTH-1:0]   dividend_mag, divisor_mag;
  logic [WIDTH-1:0]   trial;
  logic               take;

`ifdef SEQ_DIV_SIGNED_EN
  assign signed_op = bus.op_signed;
`else
  logic unused_op_signed;
  assign unused_op_signed = bus.op_signed;
  assign signed_op        = 1'b0;
`endif

  assign dividend_mag = (signed_op && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
  assign divisor_mag  = (signed_op && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

  assign trial = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
  // A set R MSB means the shifted trial is >= 2^WIDTH > D, so subtract regardless of the
  // subtractor's borrow; the wrapped difference is still exact.
  assign take  = rem_q[WIDTH-1] | sub_no_borrow;

  always_comb begin
    state_d     = state_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    sub_a       = '0;
    sub_b       = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            // Division by zero reports the raw dividend regardless of signedness.
            quotient_d  = '1;
            remainder_d = bus.dividend;
            state_d     = StDone;
          end else begin
            quo_d     = dividend_mag;
            rem_d     = '0;
            dvs_d     = divisor_mag;
            cnt_d     = COUNT_W'(WIDTH);
            neg_quo_d = signed_op & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            neg_rem_d = signed_op & bus.dividend[WIDTH-1];
            state_d   = StIter;
          end
        end
      end
      StIter: begin
        sub_a = trial;
        sub_b = dvs_q;
        rem_d = take ? sub_diff : trial;
        quo_d = {quo_q[WIDTH-2:0], take};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == COUNT_W'(1)) begin
`ifdef SEQ_DIV_SIGNED_EN
          state_d = StFix;
`else
          quotient_d  = quo_d;
          remainder_d = rem_d;
          state_d     = StDone;
`endif
        end
      end
      StFix: begin
        quotient_d  = neg_quo_q ? -quo_q : quo_q;
        remainder_d = neg_rem_q ? -rem_q : rem_q;
        state_d     = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase

    // Flush beats everything, including a simultaneous start, and leaves results untouched.
    if (bus.flush) begin
      state_d     = StIdle;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign bus.busy         = (state_q != StIdle);
  assign bus.result_valid = (state_q == StDone) && !bus.flush;
  assign bus.quotient     = quotient_q;
  assign bus.remainder    = remainder_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider with a behavioural subtractor.
// Expected results are pushed when a start is driven and popped when result_valid is seen.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] sub_a, sub_b, sub_diff;
  logic        sub_no_borrow;

  seq_divider_if #(.WIDTH(32)) bus ();

  seq_divider #(.WIDTH(32), .COUNT_W(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .sub_a         (sub_a),
    .sub_b         (sub_b),
    .sub_diff      (sub_diff),
    .sub_no_borrow (sub_no_borrow)
  );

  assign sub_diff      = sub_a - sub_b;
  assign sub_no_borrow = (sub_a >= sub_b);

  always #5 clk = ~clk;

  // Edges from the accepting edge to the first edge that starts the result_valid cycle.
`ifdef SEQ_DIV_SIGNED_EN
  localparam int LatEdges = 33;
`else
  localparam int LatEdges = 32;
`endif

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          n;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic [31:0] q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
`ifdef SEQ_DIV_SIGNED_EN
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'd0};
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
      return {q, r};
    end
`else
    if (sgn) begin
      // op_signed has no effect in this build.
    end
`endif
    q = a / b;
    r = a % b;
    return {q, r};
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.result_valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", {31'b0, bus.result_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", bus.quotient, e.q);
        check("remainder", bus.remainder, e.r);
        check("latency", 32'(cyc - e.n), 32'(e.lat));
        check("busy_at_valid", {31'b0, bus.busy}, 32'd1);
      end
    end
  end

  task automatic div_go(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input bit track);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.op_signed = sgn;
    if (track) begin
      exp_t        e;
      logic [63:0] res;
      res   = model(a, b, sgn);
      e.q   = res[63:32];
      e.r   = res[31:0];
      e.n   = cyc + 1;
      e.lat = (b == 32'd0) ? 0 : LatEdges;
      sb.push_back(e);
      last_q = e.q;
      last_r = e.r;
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", {31'b0, bus.busy}, 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", sb.size(), 32'd0);
    sb.delete();
    @(negedge clk);
    check("busy_after_done", {31'b0, bus.busy}, 32'd0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.flush     = 1'b0;
    bus.op_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;

    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_valid", {31'b0, bus.result_valid}, 32'd0);
    check("rst_quotient", bus.quotient, 32'd0);
    check("rst_remainder", bus.remainder, 32'd0);
    check("rst_sub_a", sub_a, 32'd0);
    check("rst_sub_b", sub_b, 32'd0);
    rst = 1'b0;

    div_go(32'd100, 32'd7, 1'b0, 1'b1);                    wait_done();
    div_go(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 1'b1);      wait_done();
    div_go(32'h1234_5678, 32'd0, 1'b0, 1'b1);              wait_done();
    div_go(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);              wait_done();
    div_go(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);      wait_done();
    div_go(32'hFFFF_FFF9, 32'd0, 1'b1, 1'b1);              wait_done();
    div_go(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1);              wait_done();

    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      div_go(a, b, 1'(i % 2), 1'b1);
      wait_done();
    end

    // Flush: 100/7 untracked, ignored start mid-run, flush, results must hold.
    div_go(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 32'd50;
    bus.divisor  = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.flush = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.start = 1'b0;
    check("flush_busy", {31'b0, bus.busy}, 32'd0);
    check("flush_hold_q", bus.quotient, last_q);
    check("flush_hold_r", bus.remainder, last_r);
    repeat (40) @(negedge clk);
    check("flush_still_idle", {31'b0, bus.busy}, 32'd0);
    div_go(32'd9, 32'd3, 1'b0, 1'b1);                      wait_done();

    // Reset in the middle of an iteration.
    div_go(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", {31'b0, bus.busy}, 32'd0);
    check("midrst_valid", {31'b0, bus.result_valid}, 32'd0);
    check("midrst_quotient", bus.quotient, 32'd0);
    check("midrst_remainder", bus.remainder, 32'd0);
    check("midrst_sub_a", sub_a, 32'd0);
    check("midrst_sub_b", sub_b, 32'd0);
    rst = 1'b0;
    div_go(32'd1000, 32'd33, 1'b0, 1'b1);                  wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
